// File: rtl/pwm_audio_out.sv
// Audio output stage: gain + saturation to an offset-binary code, double-buffered
// into a free-running PWM so a new code only takes effect at a period boundary.
module pwm_audio_out #(
    parameter int PWM_BITS   = 8,
    parameter int DIV        = 1,
    parameter int GAIN_SHIFT = 0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               ready_in,
    input  logic signed [15:0] signal_in,
    input  logic               enable_in,
    output logic               pwm_out,
    output logic               period_start_out,
    output logic               underrun_out,
    output logic [7:0]         overrun_count_out
);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [PWM_BITS-1:0] MID_CODE = {1'b1, {(PWM_BITS-1){1'b0}}};

    int                  scaled;
    logic [PWM_BITS-1:0] code;
    logic                tick;
    logic                boundary;

    logic [PRE_W-1:0]    prescale_q, prescale_d;
    logic [PWM_BITS-1:0] count_q, count_d;
    logic [PWM_BITS-1:0] pending_q, pending_d;
    logic                pendingValid_q, pendingValid_d;
    logic [PWM_BITS-1:0] active_q, active_d;
    logic                pwm_q, pwm_d;
    logic                periodStart_q, periodStart_d;
    logic                underrun_q, underrun_d;
    logic [7:0]          overrun_q, overrun_d;

    // Saturate in a wide signed domain, then flip the sign bit for offset binary.
    always_comb begin
        scaled = int'(signal_in) <<< GAIN_SHIFT;
        if (scaled > 32767) begin
            code = '1;
        end else if (scaled < -32768) begin
            code = '0;
        end else begin
            code = scaled[15 -: PWM_BITS] ^ MID_CODE;
        end
    end

    assign tick     = (prescale_q == PRE_LAST);
    assign boundary = tick && (count_q == CNT_LAST);

    // A strobe coinciding with a boundary lands behind the code being promoted, so it is no overrun.
    always_comb begin
        prescale_d     = tick ? '0 : prescale_q + PRE_W'(1);
        count_d        = tick ? count_q + PWM_BITS'(1) : count_q;
        pending_d      = pending_q;
        pendingValid_d = pendingValid_q;
        active_d       = active_q;
        overrun_d      = overrun_q;
        underrun_d     = 1'b0;
        periodStart_d  = boundary;
        pwm_d          = enable_in & (count_q < active_q);

        if (boundary) begin
            if (pendingValid_q) begin
                active_d       = pending_q;
                pendingValid_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (ready_in) begin
            pending_d      = code;
            pendingValid_d = 1'b1;
            if (pendingValid_q && !boundary && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prescale_q     <= '0;
            count_q        <= '0;
            pending_q      <= MID_CODE;
            pendingValid_q <= 1'b0;
            active_q       <= MID_CODE;
            pwm_q          <= 1'b0;
            periodStart_q  <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 8'd0;
        end else begin
            prescale_q     <= prescale_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            pendingValid_q <= pendingValid_d;
            active_q       <= active_d;
            pwm_q          <= pwm_d;
            periodStart_q  <= periodStart_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
        end
    end

    assign pwm_out           = pwm_q;
    assign period_start_out  = periodStart_q;
    assign underrun_out      = underrun_q;
    assign overrun_count_out = overrun_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: two instances (gain 0 and gain 4); per-period duty,
// underrun and overrun expectations are queued by the stimulus and popped by monitors.
module tb_pwm_audio_out;
    typedef struct {
        int highCycles;
        int underrun;
        int overruns;
    } periodRec_t;

    logic             clk_in    = 1'b0;
    logic             rst_in    = 1'b1;
    logic             enable_in = 1'b1;
    logic [1:0]       readyV    = '0;
    logic [1:0][15:0] signalV   = '0;
    logic [1:0]       pwmV;
    logic [1:0]       psV;
    logic [1:0]       underV;
    logic [1:0][7:0]  ovrV;

    int         edgeCount;
    int         checkCount = 0;
    int         errorCount = 0;
    periodRec_t expQ0[$];
    periodRec_t expQ1[$];

    always #5 clk_in = ~clk_in;

    // Edges since the last reset edge; drives the hand-computed stimulus schedule.
    always @(posedge clk_in) begin
        if (rst_in) edgeCount <= 0;
        else        edgeCount <= edgeCount + 1;
    end

    pwm_audio_out #(.PWM_BITS(8), .DIV(1), .GAIN_SHIFT(0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(readyV[0]), .signal_in(signalV[0]),
        .enable_in(enable_in), .pwm_out(pwmV[0]), .period_start_out(psV[0]),
        .underrun_out(underV[0]), .overrun_count_out(ovrV[0])
    );

    pwm_audio_out #(.PWM_BITS(8), .DIV(1), .GAIN_SHIFT(2)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .ready_in(readyV[1]), .signal_in(signalV[1]),
        .enable_in(enable_in), .pwm_out(pwmV[1]), .period_start_out(psV[1]),
        .underrun_out(underV[1]), .overrun_count_out(ovrV[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void pushExp(input int idx, input int h, input int u, input int o);
        periodRec_t r;
        r.highCycles = h;
        r.underrun   = u;
        r.overruns   = o;
        if (idx == 0) expQ0.push_back(r);
        else          expQ1.push_back(r);
    endfunction

    function automatic int expCount(input int idx);
        return (idx == 0) ? expQ0.size() : expQ1.size();
    endfunction

    function automatic periodRec_t popExp(input int idx);
        if (idx == 0) return expQ0.pop_front();
        return expQ1.pop_front();
    endfunction

    // Returns #1 after edge e-1, so anything driven now is sampled at edge e.
    task automatic waitUntilEdge(input int e);
        while (edgeCount < e - 1) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input int idx, input int atEdge, input logic [15:0] sample);
        waitUntilEdge(atEdge);
        readyV[idx]  = 1'b1;
        signalV[idx] = sample;
        @(posedge clk_in);
        #1;
        readyV[idx] = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s dut%0d pwm_out", tag, i), int'(pwmV[i]), 0);
            checkOutput($sformatf("%s dut%0d period_start_out", tag, i), int'(psV[i]), 0);
            checkOutput($sformatf("%s dut%0d underrun_out", tag, i), int'(underV[i]), 0);
            checkOutput($sformatf("%s dut%0d overrun_count_out", tag, i), int'(ovrV[i]), 0);
        end
    endtask

    // A period's pwm samples trail period_start_out by one cycle; the window closes
    // when the next period begins, and flags are those seen on the start cycle.
    task automatic runMonitor(input int idx);
        bit         started = 1'b0;
        bit         psDly   = 1'b0;
        int         acc     = 0;
        int         len     = 0;
        int         period  = 0;
        int         curUnder  = 0;
        int         curOvr    = 0;
        int         nextUnder = 0;
        int         nextOvr   = 0;
        periodRec_t r;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                started = 1'b0;
                psDly   = 1'b0;
            end else begin
                if (psDly) begin
                    if (started) begin
                        period++;
                        if (expCount(idx) == 0) begin
                            checkOutput($sformatf("dut%0d unexpected period %0d", idx, period), 1, 0);
                        end else begin
                            r = popExp(idx);
                            checkOutput($sformatf("dut%0d period %0d high cycles", idx, period), acc, r.highCycles);
                            checkOutput($sformatf("dut%0d period %0d length", idx, period), len, 256);
                            checkOutput($sformatf("dut%0d period %0d underrun", idx, period), curUnder, r.underrun);
                            checkOutput($sformatf("dut%0d period %0d overrun count", idx, period), curOvr, r.overruns);
                        end
                    end
                    started  = 1'b1;
                    acc      = 0;
                    len      = 0;
                    curUnder = nextUnder;
                    curOvr   = nextOvr;
                end
                if (started) begin
                    acc += int'(pwmV[idx]);
                    len++;
                end
                if (psV[idx]) begin
                    nextUnder = int'(underV[idx]);
                    nextOvr   = int'(ovrV[idx]);
                end
                psDly = psV[idx];
            end
        end
    endtask

    initial begin
        fork
            runMonitor(0);
            runMonitor(1);
        join_none
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        checkResetState("power-on reset");
        rst_in = 1'b0;

        // Idle: silence code 128, underrun on every boundary.
        pushExp(0, 128, 1, 0); pushExp(0, 128, 1, 0);
        pushExp(1, 128, 1, 0); pushExp(1, 128, 1, 0);

        applyStimulus(0, 612, 16'h7FFF);   pushExp(0, 255, 0, 0);
        applyStimulus(1, 662, 16'h1000);   pushExp(1, 192, 0, 0);
        applyStimulus(0, 868, 16'h8000);   pushExp(0, 0, 0, 0); pushExp(0, 0, 1, 0);
        applyStimulus(1, 918, 16'h2000);   pushExp(1, 255, 0, 0);
        applyStimulus(1, 1174, 16'hD000);  pushExp(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) pushExp(1, 0, 1, 0);

        // Codes 10, 20, 30 inside one period: last wins, two overruns.
        applyStimulus(0, 1290, 16'h8A00);
        applyStimulus(0, 1300, 16'h9400);
        applyStimulus(0, 1310, 16'h9E00);
        pushExp(0, 30, 0, 2);

        // Code 50 pending, code 70 arrives exactly on the wrap edge.
        applyStimulus(0, 1636, 16'hB200);  pushExp(0, 50, 0, 2);
        applyStimulus(0, 1792, 16'hC600);  pushExp(0, 70, 0, 2);

        // 398 overruns in total: count climbs to 201 then saturates at 255.
        for (int e = 2049; e <= 2248; e++) applyStimulus(0, e, 16'h4000);
        pushExp(0, 192, 0, 201);
        for (int e = 2305; e <= 2504; e++) applyStimulus(0, e, 16'h4000);
        pushExp(0, 192, 0, 255);

        // Mid-period reset with a sample pending.
        applyStimulus(0, 2836, 16'h4000);
        waitUntilEdge(2876);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        checkResetState("mid-period reset");
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Enable low for counter values 50..149 of the first period: 50 high cycles remain.
        pushExp(0, 50, 1, 0);  pushExp(0, 128, 1, 0);
        pushExp(1, 50, 1, 0);  pushExp(1, 128, 1, 0);
        waitUntilEdge(307);
        enable_in = 1'b0;
        waitUntilEdge(350);
        checkOutput("dut0 pwm_out while disabled", int'(pwmV[0]), 0);
        checkOutput("dut1 pwm_out while disabled", int'(pwmV[1]), 0);
        waitUntilEdge(407);
        enable_in = 1'b1;

        waitUntilEdge(776);
        checkOutput("dut0 unconsumed expectations", expQ0.size(), 0);
        checkOutput("dut1 unconsumed expectations", expQ1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
